gin_bus_mc_fifo: RTL
====================

Name: gin_bus_mc_fifo

Overview:
- Next-generation GLB-to-PE-array global input network (GIN) bus.
- Routes each tagged input packet to every slave whose programmed ID matches the tag. The all-ones tag is a broadcast to all slaves.
- Each slave has its own FIFO, so one stalled PE stalls the bus only when that PE is a destination of the current packet. A non-destination PE never causes a stall.
- Sits between the GLB read port and one PE row/column.

Parameters:
- ID_BITWIDTH, 4, width of tag and slave IDs; the all-ones value is reserved for broadcast.
- DATA_BITWIDTH, 8, payload width delivered to each slave.
- SLV_NUM, 6, number of slave ports.
- FIFO_DEPTH, 2, entries per slave FIFO; power of two, minimum 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_packet  in  ID_BITWIDTH+DATA_BITWIDTH  {tag, data}; tag is in the MSBs.
- i_valid  in  1  input packet valid.
- o_ready  out  1  input packet accepted when i_valid & o_ready.
- o_packet  out  SLV_NUM*DATA_BITWIDTH  per-slave data; slave i occupies bits [i*DATA_BITWIDTH +: DATA_BITWIDTH].
- o_valid  out  SLV_NUM  per-slave valid.
- i_ready  in  SLV_NUM  per-slave ready.
- i_id  in  SLV_NUM*ID_BITWIDTH  new slave IDs.
- i_id_valid  in  1  load all IDs from i_id.
- o_cur_id  out  SLV_NUM*ID_BITWIDTH  currently programmed IDs.
- o_busy  out  1  any slave FIFO non-empty.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - all IDs = 0 and all FIFOs empty;
  - o_valid = 0, o_busy = 0, o_packet = 0;
  - o_ready is 1 after reset (all FIFOs empty).
- ID load:
  - On i_id_valid at a clock edge, all IDs are replaced.
  - The new IDs take effect from the next cycle.
  - A packet handshaken in the same cycle is matched against the old IDs.
- Match:
  - match[i] = (tag == id[i]) | (tag == all-ones).
  - Slave ID all-ones is legal. It receives broadcasts only, because any tag equal to all-ones is a broadcast.
- Acceptance:
  - o_ready = AND over i of (!match[i] | !full[i]). It is combinational from i_packet and registered state.
  - On a handshake, the data is pushed into every matched FIFO in the same edge (atomic multicast).
  - A packet with no match is accepted and dropped (o_ready = 1).
- Full FIFO with simultaneous pop: o_ready uses the registered full flag (no lookahead), so the packet waits one cycle. This gives no combinational path from i_ready to o_ready.
- Output side:
  - o_valid[i] = FIFO i non-empty; o_packet slice = FIFO i head (registered storage, no bypass).
  - Latency is 1 cycle from input handshake to o_valid.
  - A slave pops on o_valid[i] & i_ready[i]. Push and pop in the same cycle keep the count unchanged.
- Ordering: per-slave delivery order equals acceptance order.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits; full = (count == FIFO_DEPTH).
- o_busy = OR of non-empty flags.
- Protocol:
  - Once o_valid[i] is high it stays high and data stays stable until popped.
  - The upstream source must hold i_packet stable while i_valid & !o_ready.
- Mid-operation reset: contents are discarded and no partial outputs appear after release.

Optional Feature:
- Macro GIN_BUS_STATS_EN.
- When defined, adds these outputs, all cleared by reset and saturating at all-ones:
  - o_drop_cnt (16 bit): increments on each accepted packet with zero matches.
  - o_stall_cnt (16 bit): increments each cycle with i_valid & !o_ready.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package gin_pkg:
  - broadcast-tag function bcast_tag(ID_BITWIDTH) returning all-ones;
  - clog2 helper;
  - stat counter width constant GIN_STAT_W = 16.
- Sub-module gin_slv_fifo, instantiated once per slave in a generate loop:
  - parameters DATA_BITWIDTH and FIFO_DEPTH;
  - ports: push, data in, pop, full, empty, head data.
- ID registers, match logic and acceptance logic live in the top.

Test Plan:
- Reset, then load IDs {0,1,2,3,4,5}, send tag 2 data 0xA5 -> o_valid = 6'b000100 one cycle later, slave 2 data 0xA5, o_ready stays 1.
- Broadcast tag 4'hF data 0x3C with all i_ready=1 -> all six o_valid high for one cycle, each slave data 0x3C.
- Slave 1 i_ready=0, send 3 packets with tag 1 (depth 2), then tag 3 -> first two accepted, third stalls (o_ready=0). Raise i_ready[1] -> third accepted one cycle later. Tag-3 packet is accepted immediately once it becomes the current packet, regardless of slave 1.
- IDs all 7, send tag 7 while asserting i_id_valid with IDs all 9 in the same cycle -> packet delivered to all six slaves. A following tag-7 packet is dropped (no o_valid); with GIN_BUS_STATS_EN, o_drop_cnt = 1.
- Fill slave 0 FIFO, pull i_rst low mid-transfer -> o_valid=0, o_busy=0, o_cur_id=0 immediately (asynchronous). After release o_ready=1 and no stale data appears.

Source files
------------

// File: rtl/gin_pkg.sv
// Shared constants and helpers for the GIN multicast bus.
package gin_pkg;

  localparam int unsigned GIN_STAT_W = 16;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // All-ones tag of the given width; callers truncate to their tag width.
  function automatic logic [31:0] bcast_tag(input int unsigned w);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gin_slv_fifo.sv
// Per-slave FIFO: registered storage, head read straight from the array.
module gin_slv_fifo
  import gin_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [DATA_BITWIDTH-1:0] i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [DATA_BITWIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_BITWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITWIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic                     do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = i_push & ~full_q;
    do_pop   = i_pop & ~empty_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (cnt_d == CNT_W'(FIFO_DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/gin_bus_mc_fifo.sv
// GIN multicast bus: tag/ID match, atomic multicast push into per-slave FIFOs.
// Optional drop/stall counters are enabled with GIN_BUS_STATS_EN.
module gin_bus_mc_fifo
  import gin_pkg::*;
#(
  parameter int unsigned ID_BITWIDTH   = 4,
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned SLV_NUM       = 6,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [ID_BITWIDTH+DATA_BITWIDTH-1:0] i_packet,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic [SLV_NUM*DATA_BITWIDTH-1:0]   o_packet,
  output logic [SLV_NUM-1:0]                 o_valid,
  input  logic [SLV_NUM-1:0]                 i_ready,
  input  logic [SLV_NUM*ID_BITWIDTH-1:0]     i_id,
  input  logic                               i_id_valid,
  output logic [SLV_NUM*ID_BITWIDTH-1:0]     o_cur_id,
  output logic                               o_busy
`ifdef GIN_BUS_STATS_EN
  ,
  output logic [GIN_STAT_W-1:0]              o_drop_cnt,
  output logic [GIN_STAT_W-1:0]              o_stall_cnt
`endif
);

  localparam logic [ID_BITWIDTH-1:0] BCAST = ID_BITWIDTH'(bcast_tag(ID_BITWIDTH));

  logic [SLV_NUM-1:0][ID_BITWIDTH-1:0]   id_q, id_d;
  logic [SLV_NUM-1:0][DATA_BITWIDTH-1:0] head;
  logic [ID_BITWIDTH-1:0]                tag;
  logic [DATA_BITWIDTH-1:0]              data;
  logic [SLV_NUM-1:0]                    match, full, empty, push, pop;
  logic                                  hs;

  assign tag  = i_packet[ID_BITWIDTH+DATA_BITWIDTH-1 -: ID_BITWIDTH];
  assign data = i_packet[DATA_BITWIDTH-1:0];

  // Acceptance uses registered full flags only, keeping i_ready off the o_ready path.
  always_comb begin
    id_d = id_q;
    if (i_id_valid) id_d = i_id;
    for (int unsigned i = 0; i < SLV_NUM; i++) begin
      match[i] = (tag == id_q[i]) | (tag == BCAST);
    end
    o_ready = &(~match | ~full);
    hs      = i_valid & o_ready;
    push    = {SLV_NUM{hs}} & match;
    pop     = ~empty & i_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) id_q <= '0;
    else        id_q <= id_d;
  end

  for (genvar g = 0; g < SLV_NUM; g++) begin : g_slv
    gin_slv_fifo #(
      .DATA_BITWIDTH(DATA_BITWIDTH),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_push (push[g]),
      .i_data (data),
      .i_pop  (pop[g]),
      .o_full (full[g]),
      .o_empty(empty[g]),
      .o_head (head[g])
    );
  end

  assign o_valid  = ~empty;
  assign o_packet = head;
  assign o_cur_id = id_q;
  assign o_busy   = |(~empty);

`ifdef GIN_BUS_STATS_EN
  logic [GIN_STAT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [GIN_STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating event counters.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (hs && (match == '0) && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + GIN_STAT_W'(1);
    if (i_valid && !o_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + GIN_STAT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_drop_cnt  = drop_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
